// File: rtl/rvfi_chk_pkg.sv
// Shared constants for the RVFI trace checker: error codes, FSM states, data width.
package rvfi_chk_pkg;

    localparam int unsigned XLEN = 32;

    // Violation codes; a lower value wins when one beat breaks several rules.
    localparam logic [3:0] ERR_NONE  = 4'd0;
    localparam logic [3:0] ERR_ORDER = 4'd1;
    localparam logic [3:0] ERR_HALT  = 4'd2;
    localparam logic [3:0] ERR_PC    = 4'd3;
    localparam logic [3:0] ERR_X0    = 4'd4;
    localparam logic [3:0] ERR_RS1   = 4'd5;
    localparam logic [3:0] ERR_RS2   = 4'd6;
    localparam logic [3:0] ERR_MEM   = 4'd7;
    localparam logic [3:0] ERR_ALIGN = 4'd8;

    // Checker FSM states.
    localparam logic [1:0] ST_FIRST  = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_HALTED = 2'd2;
    localparam logic [1:0] ST_ERROR  = 2'd3;

endpackage

// File: rtl/rvfi_shadow_rf.sv
// Shadow register file: x1..x31 with per-entry valid bits, two async reads, one sync write.
// x0 always reads as a valid zero.
module rvfi_shadow_rf
    import rvfi_chk_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_we,
    input  logic [4:0]      i_waddr,
    input  logic [XLEN-1:0] i_wdata,
    input  logic [4:0]      i_raddr_a,
    output logic [XLEN-1:0] o_rdata_a,
    output logic            o_rvalid_a,
    input  logic [4:0]      i_raddr_b,
    output logic [XLEN-1:0] o_rdata_b,
    output logic            o_rvalid_b
);

    logic [XLEN-1:0] r_mem [1:31];
    logic [31:1]     r_vld;
    logic            w_wr;

    assign w_wr = i_we && (i_waddr != 5'd0);

    // Valid bits: cleared on reset, set on the first write to an entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vld <= '0;
        end else if (w_wr) begin
            r_vld[i_waddr] <= 1'b1;
        end
    end

    // Data storage needs no reset; the valid bits qualify it.
    always_ff @(posedge i_clk) begin
        if (w_wr) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Async read ports with x0 hard-wired.
    always_comb begin
        o_rdata_a  = '0;
        o_rvalid_a = 1'b1;
        o_rdata_b  = '0;
        o_rvalid_b = 1'b1;
        if (i_raddr_a != 5'd0) begin
            o_rdata_a  = r_mem[i_raddr_a];
            o_rvalid_a = r_vld[i_raddr_a];
        end
        if (i_raddr_b != 5'd0) begin
            o_rdata_b  = r_mem[i_raddr_b];
            o_rvalid_b = r_vld[i_raddr_b];
        end
    end

endmodule

// File: rtl/rvfi_trace_checker.sv
// RVFI retirement-channel consumer: checks each retired beat for order, PC continuity,
// register consistency against a shadow file and memory-mask sanity; latches the first
// violation and counts retired/trapped beats.
module rvfi_trace_checker
    import rvfi_chk_pkg::*;
#(
    parameter logic [63:0] ORDER_START = 64'd1,
    parameter int unsigned CHECK_PC    = 1,
    parameter int unsigned CHECK_REGS  = 1,
    parameter int unsigned CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rvfi_valid,
    input  logic [63:0]      i_rvfi_order,
    input  logic [31:0]      i_rvfi_insn,
    input  logic             i_rvfi_trap,
    input  logic             i_rvfi_halt,
    input  logic             i_rvfi_intr,
    input  logic [XLEN-1:0]  i_rvfi_pc_rdata,
    input  logic [XLEN-1:0]  i_rvfi_pc_wdata,
    input  logic [4:0]       i_rvfi_rd_addr,
    input  logic [XLEN-1:0]  i_rvfi_rd_wdata,
    input  logic [4:0]       i_rvfi_rs1_addr,
    input  logic [XLEN-1:0]  i_rvfi_rs1_rdata,
    input  logic [4:0]       i_rvfi_rs2_addr,
    input  logic [XLEN-1:0]  i_rvfi_rs2_rdata,
    input  logic [3:0]       i_rvfi_mem_rmask,
    input  logic [3:0]       i_rvfi_mem_wmask,
    output logic             o_err,
    output logic [3:0]       o_err_code,
    output logic [63:0]      o_err_order,
    output logic [XLEN-1:0]  o_err_pc,
    output logic [31:0]      o_err_insn,
    output logic [CNT_W-1:0] o_retired_cnt,
    output logic [CNT_W-1:0] o_trap_cnt
);

    logic [1:0]      r_state;
    logic [63:0]     r_exp_order;
    logic [XLEN-1:0] r_exp_pc;

    logic [XLEN-1:0] w_rs1_val;
    logic [XLEN-1:0] w_rs2_val;
    logic            w_rs1_vld;
    logic            w_rs2_vld;
    logic            w_active;
    logic            w_upd;
    logic [3:0]      w_code;

    // Shadow writes happen only for clean beats, so reads see pre-update contents.
    rvfi_shadow_rf u_shadow (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_we       (w_upd),
        .i_waddr    (i_rvfi_rd_addr),
        .i_wdata    (i_rvfi_rd_wdata),
        .i_raddr_a  (i_rvfi_rs1_addr),
        .o_rdata_a  (w_rs1_val),
        .o_rvalid_a (w_rs1_vld),
        .i_raddr_b  (i_rvfi_rs2_addr),
        .o_rdata_b  (w_rs2_val),
        .o_rvalid_b (w_rs2_vld)
    );

    assign w_active = i_rvfi_valid && (r_state != ST_ERROR);
    assign w_upd    = w_active && (w_code == ERR_NONE);

    // Beat checks in priority order; the first rule that fires supplies the code.
    always_comb begin
        w_code = ERR_NONE;
        if (i_rvfi_order != r_exp_order) begin
            w_code = ERR_ORDER;
        end else if (r_state == ST_HALTED) begin
            w_code = ERR_HALT;
        end else if ((CHECK_PC != 0) && (r_state == ST_RUN) && !i_rvfi_intr &&
                     (i_rvfi_pc_rdata != r_exp_pc)) begin
            w_code = ERR_PC;
        end else if ((i_rvfi_rd_addr == 5'd0) && (i_rvfi_rd_wdata != '0)) begin
            w_code = ERR_X0;
        end else if ((CHECK_REGS != 0) && w_rs1_vld && (i_rvfi_rs1_rdata != w_rs1_val)) begin
            w_code = ERR_RS1;
        end else if ((CHECK_REGS != 0) && w_rs2_vld && (i_rvfi_rs2_rdata != w_rs2_val)) begin
            w_code = ERR_RS2;
        end else if (((i_rvfi_mem_rmask != 4'd0) && (i_rvfi_mem_wmask != 4'd0)) ||
                     (((i_rvfi_mem_rmask | i_rvfi_mem_wmask) != 4'd0) && i_rvfi_trap)) begin
            w_code = ERR_MEM;
        end else if (!i_rvfi_trap && (i_rvfi_pc_wdata[1:0] != 2'b00)) begin
            w_code = ERR_ALIGN;
        end
    end

    // FSM, expectations and first-error capture; everything freezes once in ERROR.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= ST_FIRST;
            r_exp_order <= ORDER_START;
            r_exp_pc    <= '0;
            o_err       <= 1'b0;
            o_err_code  <= ERR_NONE;
            o_err_order <= '0;
            o_err_pc    <= '0;
            o_err_insn  <= '0;
        end else if (w_active) begin
            if (w_code != ERR_NONE) begin
                r_state     <= ST_ERROR;
                o_err       <= 1'b1;
                o_err_code  <= w_code;
                o_err_order <= i_rvfi_order;
                o_err_pc    <= i_rvfi_pc_rdata;
                o_err_insn  <= i_rvfi_insn;
            end else begin
                r_exp_order <= i_rvfi_order + 64'd1;
                r_exp_pc    <= i_rvfi_pc_wdata;
                if (i_rvfi_halt) begin
                    r_state <= ST_HALTED;
                end else if (r_state == ST_FIRST) begin
                    r_state <= ST_RUN;
                end
            end
        end
    end

    // Saturating beat counters; they keep running through ERROR and HALTED.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_retired_cnt <= '0;
            o_trap_cnt    <= '0;
        end else if (i_rvfi_valid) begin
            if (o_retired_cnt != '1) begin
                o_retired_cnt <= o_retired_cnt + 1'b1;
            end
            if (i_rvfi_trap && (o_trap_cnt != '1)) begin
                o_trap_cnt <= o_trap_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rvfi_trace_checker.sv
// Directed bench for rvfi_trace_checker. A second instance with register checks off and
// 2-bit counters shares the same stimulus.
module tb_rvfi_trace_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [63:0] order;
    logic [31:0] insn;
    logic        trap, halt, intr;
    logic [31:0] pc_r, pc_w;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] rd_wd, rs1_d, rs2_d;
    logic [3:0]  rmask, wmask;

    logic        err0, err1;
    logic [3:0]  code0, code1;
    logic [63:0] eord0, eord1;
    logic [31:0] epc0, epc1, eins0, eins1;
    logic [31:0] ret0, trp0;
    logic [1:0]  ret1, trp1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rvfi_trace_checker dut0 (
        .i_clk(clk), .i_rst(rst), .i_rvfi_valid(valid), .i_rvfi_order(order),
        .i_rvfi_insn(insn), .i_rvfi_trap(trap), .i_rvfi_halt(halt), .i_rvfi_intr(intr),
        .i_rvfi_pc_rdata(pc_r), .i_rvfi_pc_wdata(pc_w), .i_rvfi_rd_addr(rd),
        .i_rvfi_rd_wdata(rd_wd), .i_rvfi_rs1_addr(rs1), .i_rvfi_rs1_rdata(rs1_d),
        .i_rvfi_rs2_addr(rs2), .i_rvfi_rs2_rdata(rs2_d), .i_rvfi_mem_rmask(rmask),
        .i_rvfi_mem_wmask(wmask), .o_err(err0), .o_err_code(code0), .o_err_order(eord0),
        .o_err_pc(epc0), .o_err_insn(eins0), .o_retired_cnt(ret0), .o_trap_cnt(trp0)
    );

    rvfi_trace_checker #(.CHECK_REGS(0), .CNT_W(2)) dut1 (
        .i_clk(clk), .i_rst(rst), .i_rvfi_valid(valid), .i_rvfi_order(order),
        .i_rvfi_insn(insn), .i_rvfi_trap(trap), .i_rvfi_halt(halt), .i_rvfi_intr(intr),
        .i_rvfi_pc_rdata(pc_r), .i_rvfi_pc_wdata(pc_w), .i_rvfi_rd_addr(rd),
        .i_rvfi_rd_wdata(rd_wd), .i_rvfi_rs1_addr(rs1), .i_rvfi_rs1_rdata(rs1_d),
        .i_rvfi_rs2_addr(rs2), .i_rvfi_rs2_rdata(rs2_d), .i_rvfi_mem_rmask(rmask),
        .i_rvfi_mem_wmask(wmask), .o_err(err1), .o_err_code(code1), .o_err_order(eord1),
        .o_err_pc(epc1), .o_err_insn(eins1), .o_retired_cnt(ret1), .o_trap_cnt(trp1)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        valid = 1'b0; order = '0; insn = '0; trap = 1'b0; halt = 1'b0; intr = 1'b0;
        pc_r = '0; pc_w = '0; rd = '0; rd_wd = '0; rs1 = '0; rs1_d = '0;
        rs2 = '0; rs2_d = '0; rmask = '0; wmask = '0;
    endtask

    // One valid beat; extra fields are set by the caller beforehand and cleared here.
    task automatic beat(input logic [63:0] o, input logic [31:0] pr, input logic [31:0] pw);
        order = o; pc_r = pr; pc_w = pw; valid = 1'b1;
        @(posedge clk); #1;
        clr();
    endtask

    task automatic do_reset();
        clr();
        rst = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    initial begin
        clr();
        do_reset();
        chk("rst_err", err0, 0);
        chk("rst_code", code0, 0);
        chk("rst_order", eord0, 0);
        chk("rst_pc", epc0, 0);
        chk("rst_insn", eins0, 0);
        chk("rst_ret", ret0, 0);
        chk("rst_trap", trp0, 0);

        // Clean stream, then one more beat to saturate the 2-bit counter.
        rd = 5'd1; rd_wd = 32'd5;
        beat(64'd1, 32'h0, 32'h4);
        rs1 = 5'd1; rs1_d = 32'd5;
        beat(64'd2, 32'h4, 32'h8);
        beat(64'd3, 32'h8, 32'hC);
        chk("clean_err", err0, 0);
        chk("clean_ret", ret0, 3);
        chk("clean_ret_w2", ret1, 3);
        beat(64'd4, 32'hC, 32'h10);
        chk("sat_ret", ret0, 4);
        chk("sat_ret_w2", ret1, 3);
        chk("sat_err", err0, 0);

        // Order gap.
        do_reset();
        beat(64'd1, 32'h0, 32'h4);
        insn = 32'hDEADBEEF;
        beat(64'd3, 32'h4, 32'h8);
        chk("gap_err", err0, 1);
        chk("gap_code", code0, 1);
        chk("gap_order", eord0, 3);
        chk("gap_pc", epc0, 32'h4);
        chk("gap_insn", eins0, 32'hDEADBEEF);

        // PC break, then the same jump flagged as an interrupt entry.
        do_reset();
        beat(64'd1, 32'h0, 32'h4);
        beat(64'd2, 32'h8, 32'hC);
        chk("pc_code", code0, 3);
        chk("pc_pc", epc0, 32'h8);
        do_reset();
        beat(64'd1, 32'h0, 32'h4);
        intr = 1'b1;
        beat(64'd2, 32'h8, 32'hC);
        chk("pc_intr_err", err0, 0);

        // Stale shadow read on rs2; ignored when register checks are off.
        do_reset();
        rd = 5'd5; rd_wd = 32'h11;
        beat(64'd1, 32'h0, 32'h4);
        rs2 = 5'd5; rs2_d = 32'h12;
        beat(64'd2, 32'h4, 32'h8);
        chk("stale_code", code0, 6);
        chk("stale_noregs_err", err1, 0);

        // Same-beat rd==rs1 compares the old value.
        do_reset();
        rd = 5'd3; rd_wd = 32'hA;
        beat(64'd1, 32'h0, 32'h4);
        rd = 5'd3; rd_wd = 32'hB; rs1 = 5'd3; rs1_d = 32'hA;
        beat(64'd2, 32'h4, 32'h8);
        rs1 = 5'd3; rs1_d = 32'hA;
        beat(64'd3, 32'h8, 32'hC);
        chk("rdrs1_code", code0, 5);
        chk("rdrs1_order", eord0, 3);

        // Nonzero x0 read is RS1 only when register checks are on.
        do_reset();
        rs1_d = 32'h3;
        beat(64'd1, 32'h0, 32'h4);
        chk("x0rd_code", code0, 5);
        chk("x0rd_noregs", err1, 0);

        // Priority: bad order and x0 write in one beat; trap beats still counted after.
        do_reset();
        beat(64'd1, 32'h0, 32'h4);
        rd = 5'd0; rd_wd = 32'd1;
        beat(64'd7, 32'h4, 32'h8);
        chk("prio_code", code0, 1);
        trap = 1'b1;
        beat(64'd9, 32'h40, 32'h41);
        chk("prio_hold", code0, 1);
        chk("prio_hold_order", eord0, 7);
        chk("prio_trap", trp0, 1);
        chk("prio_ret", ret0, 3);

        // x0 write alone, memory mask clash, misaligned next PC.
        do_reset();
        rd_wd = 32'd1;
        beat(64'd1, 32'h0, 32'h4);
        chk("x0_code", code0, 4);
        do_reset();
        rmask = 4'h1; wmask = 4'h2;
        beat(64'd1, 32'h0, 32'h4);
        chk("mem_code", code0, 7);
        do_reset();
        rmask = 4'hF; trap = 1'b1;
        beat(64'd1, 32'h0, 32'h4);
        chk("memtrap_code", code0, 7);
        do_reset();
        beat(64'd1, 32'h0, 32'h6);
        chk("align_code", code0, 8);
        do_reset();
        trap = 1'b1;
        beat(64'd1, 32'h0, 32'h6);
        chk("align_trap_ok", err0, 0);

        // Halt then another beat; then reset mid-stream.
        do_reset();
        beat(64'd1, 32'h0, 32'h4);
        halt = 1'b1;
        beat(64'd2, 32'h4, 32'h8);
        chk("halt_quiet", err0, 0);
        beat(64'd3, 32'h8, 32'hC);
        chk("halt_code", code0, 2);
        chk("halt_ret", ret0, 3);
        do_reset();
        chk("mid_rst_err", err0, 0);
        chk("mid_rst_code", code0, 0);
        chk("mid_rst_order", eord0, 0);
        chk("mid_rst_ret", ret0, 0);
        beat(64'd1, 32'h100, 32'h104);
        beat(64'd2, 32'h104, 32'h108);
        chk("restart_err", err0, 0);
        chk("restart_ret", ret0, 2);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
